pipe_commit_trace: RTL and testbench
====================================

// Module: pipe_commit_trace
// PURPOSE
//   Synthesizable retirement tracer and performance-counter block that taps the CPU pipeline.
//   - Inputs: WB write port plus stall/flush/forward strobes.
//   - Buffers commit records in a parametrised FIFO, drained over a valid/ready port.
//   - Keeps saturating event counters, so benches and debug logic read counts instead of $display scraping.
//   - Sits beside riscv_cpu at top level; no feedback into the pipeline.
// PARAMETERS
//   XLEN        32  data/PC width
//   DEPTH       16  trace FIFO entries; power of 2, >=2
//   CNT_W       32  width of every event counter
//   SEQ_W       16  width of per-record retirement sequence number
//   TRACE_MODE  1   0: trace every valid retirement; 1: only reg_write with rd!=0
// PORTS
//   clk          in   1            clock
//   rst_n        in   1            asynchronous active-low reset
//   wb_valid     in   1            MEM/WB stage holds a valid instruction this cycle
//   wb_reg_write in   1            that instruction writes the register file
//   wb_rd        in   5            destination register
//   wb_pc        in   XLEN         PC of retiring instruction
//   wb_data      in   XLEN         value written (rf_rd_data)
//   stall_if/id/ex in 1 each       pipeline stall strobes
//   flush_if/id/ex in 1 each       pipeline flush strobes
//   forward_a/b  in   2 each       forwarding mux selects (00 = none)
//   trace_en     in   1            gates FIFO pushes only
//   cnt_clear    in   1            synchronous clear of all counters
//   trc_valid    out  1            FIFO head valid
//   trc_ready    in   1            consumer accepts head
//   trc_rec      out  trace_rec_t  {seq, pc, rd, data, reg_write}
//   fifo_level   out  $clog2(DEPTH)+1  occupancy
//   cycle_cnt, retire_cnt, stall_cnt, flush_cnt, fwd_cnt, drop_cnt   out  CNT_W  counters
// BEHAVIOUR
//   Reset
//   - All outputs 0; FIFO empty; sequence counter 0; trc_rec 0.
//   - Reset mid-drain discards all entries; no partial record is ever presented.
//   Push condition
//   - push_req = wb_valid & trace_en & (TRACE_MODE==0 | (wb_reg_write & wb_rd!=0)).
//   - Record seq = low SEQ_W bits of the running retirement count before this retirement; wraps modulo 2^SEQ_W.
//   - Latency: record pushed at edge N appears with trc_valid=1 after edge N (registered, no bypass).
//   Pop and simultaneous events
//   - pop = trc_valid & trc_ready.
//   - Push and pop in the same cycle: both occur, level unchanged. Allowed when full: pop frees the slot.
//   Full and empty
//   - Full (level==DEPTH) without pop: push dropped, drop_cnt++; FIFO contents untouched.
//   - Empty: trc_valid=0; trc_rec holds its last value, undefined for the consumer.
//   - Pointers are $clog2(DEPTH)+1 bits; wrap is natural; full/empty from MSB compare.
//   Counters (each saturates at all-ones)
//   - cycle_cnt: every cycle.
//   - retire_cnt: wb_valid.
//   - stall_cnt: any stall_*.
//   - flush_cnt: any flush_*.
//   - fwd_cnt: forward_a!=0 | forward_b!=0, +1 per cycle, not per operand.
//   - drop_cnt: dropped pushes.
//   - All counters ignore trace_en.
//   - Sequence counter advances on every wb_valid, regardless of trace_en or TRACE_MODE, so gaps expose untraced retirements.
//   cnt_clear
//   - Zeroes all six counters and the sequence counter; wins over same-cycle increments.
//   - Does not touch the FIFO.
// STRUCTURE
//   - Shared pipeline-types package: typedef trace_rec_t (packed: seq, pc, rd, data, reg_write) and TRACE_MODE_* constants.
//   - One sub-module: trace_fifo #(DEPTH, type T): sync FIFO with level, full/empty, valid/ready read side.
//   - Counters via a generate loop of identical saturating-increment logic.
// TESTING
//   1 Reset, run the 8-instr ALU program, TRACE_MODE=1, trc_ready=1
//     -> 8 records: rd x1..x8, data 5,10,15,5,10,15,10,160, seq 0..7.
//     -> NOPs not traced; retire_cnt=10.
//   2 DEPTH=4, trc_ready=0, 6 qualifying retirements
//     -> level=4, drop_cnt=2, drained seq 0..3.
//   3 Full FIFO, same-cycle push and pop -> level stays 4, drop_cnt unchanged, new seq at tail.
//   4 cnt_clear asserted in a cycle with wb_valid and a stall -> next cycle all counters 0, not 1.
//   5 trace_en=0 for 3 retirements, then 1 -> no records for those; next record seq jumps by 3.
//   6 Drive stall_id high for 2^CNT_W+2 cycles (CNT_W=4 bench) -> stall_cnt sticks at 15.
//     Then rst_n low mid-drain -> trc_valid=0, level=0 asynchronously.

Source files
------------

// File: rtl/pipe_commit_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_commit_trace_pkg : shared commit-trace record type and counter map    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package pipe_commit_trace_pkg;

   localparam int TRC_XLEN  = 32;
   localparam int TRC_SEQ_W = 16;
   localparam int TRC_RD_W  = 5;

   localparam int TRACE_MODE_ALL = 0;
   localparam int TRACE_MODE_RD  = 1;

   // Event counter slots, in output order
   localparam int NUM_CNT   = 6;
   localparam int CNT_CYCLE = 0;
   localparam int CNT_RETIRE = 1;
   localparam int CNT_STALL = 2;
   localparam int CNT_FLUSH = 3;
   localparam int CNT_FWD   = 4;
   localparam int CNT_DROP  = 5;

   typedef struct packed {
      logic [TRC_SEQ_W-1:0] seq;
      logic [TRC_XLEN-1:0]  pc;
      logic [TRC_RD_W-1:0]  rd;
      logic [TRC_XLEN-1:0]  data;
      logic                 reg_write;
   } trace_rec_t;

endpackage
`default_nettype wire

// File: rtl/pipe_commit_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_fifo : synchronous FIFO with level and a valid/ready read side       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module trace_fifo #(
   parameter int  DEPTH = 16,
   parameter type T     = logic [7:0]
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  T                         i_data,
   input  logic                     i_ready,
   output logic                     o_valid,
   output T                         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   r_wr;
   logic [AW:0]   r_rd;
   T              r_mem [DEPTH];

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic [AW-1:0] w_head_idx;

   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = !w_empty && i_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign w_push  = i_push && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
            r_wr                <= r_wr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + (AW+1)'(1);
         end
      end
   end

   // When empty, keep presenting the most recently popped slot
   assign w_head_idx = w_empty ? (r_rd[AW-1:0] - AW'(1)) : r_rd[AW-1:0];

   assign o_data  = r_mem[w_head_idx];
   assign o_valid = !w_empty;
   assign o_empty = w_empty;
   assign o_full  = w_full;
   assign o_level = r_wr - r_rd;

endmodule
`default_nettype wire

// File: rtl/pipe_commit_trace.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_commit_trace : retirement tracer FIFO plus saturating event counters  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pipe_commit_trace
   import pipe_commit_trace_pkg::*;
#(
   parameter int XLEN       = TRC_XLEN,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 32,
   parameter int SEQ_W      = TRC_SEQ_W,
   parameter int TRACE_MODE = TRACE_MODE_RD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_valid,
   input  logic                     wb_reg_write,
   input  logic [4:0]               wb_rd,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     stall_if,
   input  logic                     stall_id,
   input  logic                     stall_ex,
   input  logic                     flush_if,
   input  logic                     flush_id,
   input  logic                     flush_ex,
   input  logic [1:0]               forward_a,
   input  logic [1:0]               forward_b,
   input  logic                     trace_en,
   input  logic                     cnt_clear,
   output logic                     trc_valid,
   input  logic                     trc_ready,
   output trace_rec_t               trc_rec,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [CNT_W-1:0]         retire_cnt,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt,
   output logic [CNT_W-1:0]         fwd_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   logic [SEQ_W-1:0]                 r_seq;
   logic                             w_qual;
   logic                             w_push_req;
   logic                             w_pop;
   logic                             w_full;
   logic                             w_empty;
   logic                             w_drop;
   trace_rec_t                       w_rec;
   logic [NUM_CNT-1:0]               w_inc;
   logic [NUM_CNT-1:0][CNT_W-1:0]    w_cnt;

   assign w_qual     = (TRACE_MODE == TRACE_MODE_ALL) ? 1'b1
                                                      : (wb_reg_write && (wb_rd != 5'd0));
   assign w_push_req = wb_valid && trace_en && w_qual;
   assign w_pop      = trc_valid && trc_ready;
   assign w_drop     = w_push_req && w_full && !w_pop;

   // Record widths are fixed by the shared package type
   assign w_rec.seq       = TRC_SEQ_W'(r_seq);
   assign w_rec.pc        = TRC_XLEN'(wb_pc);
   assign w_rec.rd        = wb_rd;
   assign w_rec.data      = TRC_XLEN'(wb_data);
   assign w_rec.reg_write = wb_reg_write;

   trace_fifo #(
      .DEPTH (DEPTH),
      .T     (trace_rec_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_req),
      .i_data  (w_rec),
      .i_ready (trc_ready),
      .o_valid (trc_valid),
      .o_data  (trc_rec),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   // Sequence tracks every retirement so untraced ones show up as gaps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq <= '0;
      end else if (cnt_clear) begin
         r_seq <= '0;
      end else if (wb_valid) begin
         r_seq <= r_seq + SEQ_W'(1);
      end
   end

   assign w_inc[CNT_CYCLE]  = 1'b1;
   assign w_inc[CNT_RETIRE] = wb_valid;
   assign w_inc[CNT_STALL]  = stall_if || stall_id || stall_ex;
   assign w_inc[CNT_FLUSH]  = flush_if || flush_id || flush_ex;
   assign w_inc[CNT_FWD]    = (forward_a != 2'b00) || (forward_b != 2'b00);
   assign w_inc[CNT_DROP]   = w_drop;

   generate
      for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (cnt_clear) begin
               r_cnt <= '0;
            end else if (w_inc[g] && (r_cnt != {CNT_W{1'b1}})) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end

         assign w_cnt[g] = r_cnt;
      end
   endgenerate

   assign cycle_cnt  = w_cnt[CNT_CYCLE];
   assign retire_cnt = w_cnt[CNT_RETIRE];
   assign stall_cnt  = w_cnt[CNT_STALL];
   assign flush_cnt  = w_cnt[CNT_FLUSH];
   assign fwd_cnt    = w_cnt[CNT_FWD];
   assign drop_cnt   = w_cnt[CNT_DROP];

endmodule
`default_nettype wire

// File: tb/tb_pipe_commit_trace.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_commit_trace : randomized and directed bench with a queue model    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pipe_commit_trace;
   import pipe_commit_trace_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wb_valid, wb_reg_write;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_pc, wb_data;
   logic             stall_if, stall_id, stall_ex;
   logic             flush_if, flush_id, flush_ex;
   logic [1:0]       forward_a, forward_b;
   logic             trace_en, cnt_clear, trc_ready;
   logic             trc_valid;
   trace_rec_t       trc_rec;
   logic [2:0]       fifo_level;
   logic [CNT_W-1:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt, fwd_cnt, drop_cnt;

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   trace_rec_t m_q[$];
   trace_rec_t got_q[$];
   trace_rec_t exp_q[$];
   int         m_cnt[6];
   int         m_seq;
   logic [31:0] pc_ctr;

   always #5 clk = ~clk;

   pipe_commit_trace #(
      .XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W), .SEQ_W(16), .TRACE_MODE(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_pc(wb_pc), .wb_data(wb_data),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
      .forward_a(forward_a), .forward_b(forward_b),
      .trace_en(trace_en), .cnt_clear(cnt_clear),
      .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_rec(trc_rec),
      .fifo_level(fifo_level),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
   );

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   task automatic m_reset();
      m_q.delete();
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_seq = 0;
   endtask

   task automatic idle();
      wb_valid = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
      stall_if = 0; stall_id = 0; stall_ex = 0;
      flush_if = 0; flush_id = 0; flush_ex = 0;
      forward_a = 0; forward_b = 0; cnt_clear = 0;
   endtask

   task automatic retire(input bit rw, input logic [4:0] rd, input logic [31:0] d);
      wb_valid = 1; wb_reg_write = rw; wb_rd = rd; wb_data = d;
      wb_pc = pc_ctr; pc_ctr = pc_ctr + 4;
   endtask

   // One clock: update model from the inputs in force, then advance past the edge
   task automatic step();
      bit         full, pop, preq, drop;
      trace_rec_t rec;
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() > 0) && trc_ready;
      preq = wb_valid && trace_en && wb_reg_write && (wb_rd != 0);
      drop = 0;
      rec.seq = 16'(m_seq); rec.pc = wb_pc; rec.rd = wb_rd;
      rec.data = wb_data; rec.reg_write = wb_reg_write;
      if (trc_valid && trc_ready) got_q.push_back(trc_rec);
      if (pop) exp_q.push_back(m_q.pop_front());
      if (preq) begin
         if (!full || pop) m_q.push_back(rec);
         else drop = 1;
      end
      if (cnt_clear) begin
         for (int i = 0; i < 6; i++) m_cnt[i] = 0;
         m_seq = 0;
      end else begin
         m_cnt[0] = sat(m_cnt[0]);
         if (wb_valid) m_cnt[1] = sat(m_cnt[1]);
         if (stall_if || stall_id || stall_ex) m_cnt[2] = sat(m_cnt[2]);
         if (flush_if || flush_id || flush_ex) m_cnt[3] = sat(m_cnt[3]);
         if (forward_a != 0 || forward_b != 0) m_cnt[4] = sat(m_cnt[4]);
         if (drop) m_cnt[5] = sat(m_cnt[5]);
         if (wb_valid) m_seq = (m_seq + 1) % 65536;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      trace_en = 1; trc_ready = 0;
      rst_n = 0;
      m_reset();
      got_q.delete(); exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle();
      trace_en = 1; trc_ready = 1;
      rst_n = 0;
      m_reset();
      #3;
      vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", trc_valid); end
      vectors++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
      vectors++; if (trc_rec !== '0) begin errors++; $display("FAIL reset_rec got=%h want=0", trc_rec); end
      vectors++;
      if ({cycle_cnt, retire_cnt, stall_cnt, flush_cnt, fwd_cnt, drop_cnt} !== '0) begin
         errors++; $display("FAIL reset_cnts got=%h want=0", {cycle_cnt, retire_cnt, stall_cnt, flush_cnt, fwd_cnt, drop_cnt});
      end
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_alu_program();
      int exp_data[8];
      exp_data = '{5, 10, 15, 5, 10, 15, 10, 160};
      do_reset();
      trc_ready = 1;
      step(); step();
      for (int i = 0; i < 8; i++) begin
         retire(1, 5'(i + 1), 32'(exp_data[i]));
         step();
      end
      retire(1, 5'd0, 32'd0); step();
      retire(0, 5'd0, 32'd0); step();
      idle();
      repeat (4) step();
      vectors++; if (got_q.size() !== 8) begin errors++; $display("FAIL alu_count got=%0d want=8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i].rd !== 5'(i + 1) || got_q[i].data !== 32'(exp_data[i]) || got_q[i].seq !== 16'(i)) begin
            errors++;
            $display("FAIL alu_rec[%0d] got rd=%0d data=%0d seq=%0d want rd=%0d data=%0d seq=%0d",
                     i, got_q[i].rd, got_q[i].data, got_q[i].seq, i + 1, exp_data[i], i);
         end
      end
      vectors++; if (retire_cnt !== 4'd10) begin errors++; $display("FAIL alu_retire got=%0d want=10", retire_cnt); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         retire(1, 5'(i + 3), 32'(100 + i));
         step();
      end
      idle();
      vectors++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d want=4", fifo_level); end
      vectors++; if (drop_cnt !== 4'd2) begin errors++; $display("FAIL ovf_drop got=%0d want=2", drop_cnt); end
      trc_ready = 1;
      repeat (5) step();
      vectors++; if (got_q.size() !== 4) begin errors++; $display("FAIL ovf_drain got=%0d want=4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i].seq !== 16'(i)) begin errors++; $display("FAIL ovf_seq[%0d] got=%0d want=%0d", i, got_q[i].seq, i); end
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         retire(1, 5'd7, 32'(i)); step();
      end
      retire(1, 5'd9, 32'hABCD);
      trc_ready = 1;
      step();
      idle();
      trc_ready = 0;
      vectors++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fpp_level got=%0d want=4", fifo_level); end
      vectors++; if (drop_cnt !== 4'd0) begin errors++; $display("FAIL fpp_drop got=%0d want=0", drop_cnt); end
      trc_ready = 1;
      repeat (5) step();
      vectors++;
      if (got_q.size() !== 5 || got_q[got_q.size()-1].seq !== 16'd4 || got_q[got_q.size()-1].data !== 32'hABCD) begin
         errors++; $display("FAIL fpp_tail got n=%0d want n=5 seq=4 data=abcd", got_q.size());
      end
   endtask

   task automatic test_cnt_clear();
      trc_ready = 1;
      got_q.delete(); exp_q.delete();
      stall_ex = 1; flush_id = 1; forward_b = 2; retire(1, 5'd4, 32'd1);
      repeat (3) step();
      cnt_clear = 1;
      step();
      idle();
      vectors++;
      if ({cycle_cnt, retire_cnt, stall_cnt, flush_cnt, fwd_cnt, drop_cnt} !== '0) begin
         errors++; $display("FAIL clr_cnts got=%h want=0", {cycle_cnt, retire_cnt, stall_cnt, flush_cnt, fwd_cnt, drop_cnt});
      end
      retire(1, 5'd5, 32'd55); step();
      idle();
      vectors++; if (cycle_cnt !== 4'd1) begin errors++; $display("FAIL clr_cycle got=%0d want=1", cycle_cnt); end
      repeat (8) step();
      vectors++;
      if (got_q.size() == 0 || got_q[got_q.size()-1].seq !== 16'd0) begin
         errors++; $display("FAIL clr_seq got n=%0d want last seq=0", got_q.size());
      end
   endtask

   task automatic test_trace_en();
      do_reset();
      trc_ready = 1;
      trace_en = 0;
      for (int i = 0; i < 3; i++) begin retire(1, 5'd6, 32'(i)); step(); end
      trace_en = 1;
      retire(1, 5'd6, 32'd99); step();
      idle();
      repeat (3) step();
      vectors++;
      if (got_q.size() !== 1 || got_q[0].seq !== 16'd3) begin
         errors++; $display("FAIL ten_seq got n=%0d want n=1 seq=3", got_q.size());
      end
      vectors++; if (retire_cnt !== 4'd4) begin errors++; $display("FAIL ten_retire got=%0d want=4", retire_cnt); end
   endtask

   task automatic test_saturate_and_async_reset();
      do_reset();
      stall_id = 1;
      repeat (CMAX + 3) step();
      idle();
      vectors++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall got=%0d want=15", stall_cnt); end
      vectors++; if (cycle_cnt !== 4'd15) begin errors++; $display("FAIL sat_cycle got=%0d want=15", cycle_cnt); end
      for (int i = 0; i < 3; i++) begin retire(1, 5'd2, 32'(i)); step(); end
      idle();
      trc_ready = 1;
      step();
      #2;
      rst_n = 0;
      #1;
      vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%0b want=0", trc_valid); end
      vectors++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL arst_level got=%0d want=0", fifo_level); end
      m_reset();
      @(posedge clk); #1;
      rst_n = 1;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         wb_valid     = ($urandom_range(0, 9) < 7);
         wb_reg_write = $urandom_range(0, 3) != 0;
         wb_rd        = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wb_data      = $urandom;
         wb_pc        = $urandom;
         trace_en     = ($urandom_range(0, 9) < 8);
         trc_ready    = $urandom_range(0, 1);
         stall_if     = ($urandom_range(0, 7) == 0);
         stall_id     = ($urandom_range(0, 7) == 0);
         stall_ex     = ($urandom_range(0, 7) == 0);
         flush_if     = ($urandom_range(0, 9) == 0);
         flush_id     = ($urandom_range(0, 9) == 0);
         flush_ex     = ($urandom_range(0, 9) == 0);
         forward_a    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
         forward_b    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
         cnt_clear    = ($urandom_range(0, 19) == 0);
         step();
         vectors++;
         if (trc_valid !== (m_q.size() > 0) || fifo_level !== 3'(m_q.size())) begin
            errors++; $display("FAIL rnd_occ c=%0d got v=%0b lvl=%0d want lvl=%0d", c, trc_valid, fifo_level, m_q.size());
         end
         vectors++;
         if (cycle_cnt !== 4'(m_cnt[0]) || retire_cnt !== 4'(m_cnt[1]) || stall_cnt !== 4'(m_cnt[2]) ||
             flush_cnt !== 4'(m_cnt[3]) || fwd_cnt !== 4'(m_cnt[4]) || drop_cnt !== 4'(m_cnt[5])) begin
            errors++;
            $display("FAIL rnd_cnt c=%0d got %0d %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d %0d", c,
                     cycle_cnt, retire_cnt, stall_cnt, flush_cnt, fwd_cnt, drop_cnt,
                     m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3], m_cnt[4], m_cnt[5]);
         end
      end
      idle();
      trc_ready = 1;
      repeat (DEPTH + 2) step();
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL rnd_npop got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rnd_rec[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      pc_ctr = 32'h0000_1000;
      wb_pc = 0; trace_en = 1; trc_ready = 0;
      idle();
      rst_n = 1;
      #1;
      test_reset();
      test_alu_program();
      test_overflow();
      test_full_push_pop();
      test_cnt_clear();
      test_trace_en();
      test_saturate_and_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
